adc_spi_responder: RTL and testbench

- SPI-slave emulation of the 8-channel, 12-bit serial ADC on the board: the responder end of the ADC serial interface.
- Samples ADC_SCLK, ADC_CS_N and ADC_DIN from the ADC controller, decodes the channel address, and shifts the selected CHn value out on ADC_DOUT.
- Used in simulation and in hardware-in-loop builds to feed synthetic thermistor and sensor values to the printer controller without a physical ADC.

---
 rtl/adc_spi_responder_if.sv | 10 +
 rtl/adc_spi_responder.sv | 160 ++++++++++++++++
 tb/tb_adc_spi_responder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/adc_spi_responder_if.sv
// rtl/adc_spi_responder_if.sv - ADC serial link between controller (master) and emulated ADC (slave)
interface adc_spi_responder_if;
  logic ADC_SCLK;
  logic ADC_CS_N;
  logic ADC_DIN;
  logic ADC_DOUT;

  modport master (output ADC_SCLK, output ADC_CS_N, output ADC_DIN, input ADC_DOUT);
  modport slave  (input ADC_SCLK, input ADC_CS_N, input ADC_DIN, output ADC_DOUT);
endinterface

// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - 8-channel 12-bit serial ADC emulator, SPI responder side
// Optional LSB noise injection when ADC_RESP_NOISE_EN is defined.
module adc_spi_responder #(
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                CLOCK,
  input  logic                RESET,
  adc_spi_responder_if.slave  spi,
  input  logic [DATA_W-1:0]   CH0,
  input  logic [DATA_W-1:0]   CH1,
  input  logic [DATA_W-1:0]   CH2,
  input  logic [DATA_W-1:0]   CH3,
  input  logic [DATA_W-1:0]   CH4,
  input  logic [DATA_W-1:0]   CH5,
  input  logic [DATA_W-1:0]   CH6,
  input  logic [DATA_W-1:0]   CH7,
  output logic                FRAME_DONE,
  output logic                FRAME_ERR,
  output logic [2:0]          CUR_ADDR
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  // The extra top bit of the SCLK/CS_N chains holds the previous synchronised value.
  logic [SYNC_STAGES:0]   sclk_q, sclk_d;
  logic [SYNC_STAGES:0]   cs_q, cs_d;
  logic [SYNC_STAGES-1:0] din_q, din_d;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] shreg_q, shreg_d;
  logic [2:0]  addr_q, addr_d;
  logic [2:0]  cur_addr_q, cur_addr_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [DATA_W-1:0] ch_sel;
  logic [15:0]       load_data;
  logic              sclk_rise, sclk_fall, cs_fall, cs_rise, din_s;

  assign sclk_d = {sclk_q[SYNC_STAGES-1:0], spi.ADC_SCLK};
  assign cs_d   = {cs_q[SYNC_STAGES-1:0], spi.ADC_CS_N};
  assign din_d  = {din_q[SYNC_STAGES-2:0], spi.ADC_DIN};

  assign sclk_rise =  sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] &  sclk_q[SYNC_STAGES];
  assign cs_fall   = ~cs_q[SYNC_STAGES-1]   &  cs_q[SYNC_STAGES];
  assign cs_rise   =  cs_q[SYNC_STAGES-1]   & ~cs_q[SYNC_STAGES];
  assign din_s     =  din_q[SYNC_STAGES-1];

  always_comb begin
    ch_sel = CH0;
    case (cur_addr_q)
      3'd0: ch_sel = CH0;
      3'd1: ch_sel = CH1;
      3'd2: ch_sel = CH2;
      3'd3: ch_sel = CH3;
      3'd4: ch_sel = CH4;
      3'd5: ch_sel = CH5;
      3'd6: ch_sel = CH6;
      3'd7: ch_sel = CH7;
      default: ch_sel = CH0;
    endcase
  end

`ifdef ADC_RESP_NOISE_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == S_IDLE && cs_fall)
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end

  // Noise uses the LFSR value current at the load, before it advances.
  assign load_data = 16'(ch_sel) ^ {14'd0, lfsr_q[1:0]};
`else
  assign load_data = 16'(ch_sel);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    addr_d     = addr_q;
    cur_addr_d = cur_addr_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          shreg_d = load_data;
          cnt_d   = 4'd0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // A CS_N rise coinciding with the 16th rising edge still completes the frame.
        if (sclk_rise && cnt_q == 4'd15) begin
          cur_addr_d = addr_q;
          done_d     = 1'b1;
          shreg_d    = 16'd0;
          state_d    = cs_rise ? S_IDLE : S_DONE;
        end else if (cs_rise) begin
          err_d   = 1'b1;
          shreg_d = 16'd0;
          state_d = S_IDLE;
        end else if (sclk_rise) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q >= 4'd2 && cnt_q <= 4'd4)
            addr_d = {addr_q[1:0], din_s};
        end else if (sclk_fall) begin
          shreg_d = {shreg_q[14:0], 1'b0};
        end
      end
      S_DONE: begin
        if (cs_rise) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      sclk_q     <= '0;
      cs_q       <= '1;
      din_q      <= '0;
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      shreg_q    <= 16'd0;
      addr_q     <= 3'd0;
      cur_addr_q <= 3'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sclk_q     <= sclk_d;
      cs_q       <= cs_d;
      din_q      <= din_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      addr_q     <= addr_d;
      cur_addr_q <= cur_addr_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign spi.ADC_DOUT = shreg_q[15];
  assign FRAME_DONE   = done_q;
  assign FRAME_ERR    = err_q;
  assign CUR_ADDR     = cur_addr_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb/tb_adc_spi_responder.sv - scoreboard bench for adc_spi_responder
module tb_adc_spi_responder;
  localparam int HALF = 8;

  typedef struct packed {
    logic        is_err;
    logic [15:0] data;
    logic [2:0]  addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] ch [8];
  logic        frame_done, frame_err;
  logic [2:0]  cur_addr;
  logic [15:0] rx = 16'd0;
  logic [15:0] m_lfsr;
  exp_t        q[$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  adc_spi_responder_if spi();

  adc_spi_responder #(.DATA_W(12), .SYNC_STAGES(2)) dut (
    .CLOCK(clk), .RESET(rst_n), .spi(spi),
    .CH0(ch[0]), .CH1(ch[1]), .CH2(ch[2]), .CH3(ch[3]),
    .CH4(ch[4]), .CH5(ch[5]), .CH6(ch[6]), .CH7(ch[7]),
    .FRAME_DONE(frame_done), .FRAME_ERR(frame_err), .CUR_ADDR(cur_addr)
  );

  // Controller side: capture DOUT at every SCLK rising edge
  always @(posedge spi.ADC_SCLK) rx <= {rx[14:0], spi.ADC_DOUT};

  always @(negedge clk) begin : monitor
    exp_t e;
    if (frame_done || frame_err) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: done=%0b err=%0b addr=%0d, required no pulse",
                 frame_done, frame_err, cur_addr);
      end else begin
        e = q.pop_front();
        if (e.is_err !== frame_err || e.is_err === frame_done || cur_addr !== e.addr ||
            (!e.is_err && rx !== e.data)) begin
          bad++;
          $display("FAIL frame: done=%0b err=%0b addr=%0d data=%h, required err=%0b addr=%0d data=%h",
                   frame_done, frame_err, cur_addr, rx, e.is_err, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Expected returned word for a frame loading value v; advances the noise model per CS_N fall
  task automatic next_expect(input logic [11:0] v, output logic [15:0] d);
    d = {4'd0, v};
`ifdef ADC_RESP_NOISE_EN
    d[1:0] = d[1:0] ^ m_lfsr[1:0];
    m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`endif
  endtask

  task automatic frame(input logic [15:0] ctrl, input int nedges, input bit simul, input bit leave_open);
    spi.ADC_CS_N = 1'b0;
    spi.ADC_DIN  = ctrl[15];
    tick(HALF);
    for (int i = 0; i < nedges; i++) begin
      spi.ADC_DIN = ctrl[15-i];
      tick(HALF);
      spi.ADC_SCLK = 1'b1;
      if (simul && i == nedges - 1) spi.ADC_CS_N = 1'b1;
      tick(HALF);
      spi.ADC_SCLK = 1'b0;
    end
    if (!leave_open) begin
      spi.ADC_CS_N = 1'b1;
      tick(2*HALF);
    end else begin
      tick(HALF);
    end
  endtask

  task automatic full_frame(input logic [15:0] ctrl, input logic [11:0] v, input logic [2:0] addr, input bit simul);
    logic [15:0] d;
    next_expect(v, d);
    q.push_back('{is_err: 1'b0, data: d, addr: addr});
    frame(ctrl, 16, simul, 1'b0);
  endtask

  initial begin
    logic [15:0] d;
    rst_n = 1'b0;
    spi.ADC_CS_N = 1'b1;
    spi.ADC_SCLK = 1'b0;
    spi.ADC_DIN  = 1'b0;
    for (int i = 0; i < 8; i++) ch[i] = 12'h000;
    m_lfsr = 16'hACE1;

    for (int i = 0; i < 6; i++) begin
      spi.ADC_SCLK = ~spi.ADC_SCLK;
      tick(3);
      check("reset_dout", 32'(spi.ADC_DOUT), 32'd0);
      check("reset_pulses", {30'd0, frame_done, frame_err}, 32'd0);
    end
    check("reset_addr", 32'(cur_addr), 32'd0);
    rst_n = 1'b1;
    tick(5);

    ch[0] = 12'hABC;
    full_frame(16'h1800, ch[0], 3'd3, 1'b0);
    check("addr_frame1", 32'(cur_addr), 32'd3);

    ch[3] = 12'h5A5;
    full_frame(16'h3800, ch[3], 3'd7, 1'b0);
    check("addr_frame2", 32'(cur_addr), 32'd7);

    ch[7] = 12'hFFF;
    full_frame(16'h3800, ch[7], 3'd7, 1'b0);

    next_expect(ch[7], d);
    q.push_back('{is_err: 1'b1, data: 16'd0, addr: 3'd7});
    frame(16'h2800, 8, 1'b0, 1'b0);
    check("addr_after_abort", 32'(cur_addr), 32'd7);

    // CH7 changes mid-frame; the bits in flight must keep the value loaded at CS_N fall
    next_expect(ch[7], d);
    q.push_back('{is_err: 1'b0, data: d, addr: 3'd1});
    fork
      frame(16'h0800, 16, 1'b0, 1'b0);
      begin tick(4*HALF); ch[7] = 12'h123; end
    join
    check("addr_frame5", 32'(cur_addr), 32'd1);

    ch[1] = 12'hFFF;
    next_expect(ch[1], d);
    frame(16'h2000, 6, 1'b0, 1'b1);
    check("dout_before_reset", 32'(spi.ADC_DOUT), 32'd1);
    rst_n = 1'b0;
    #1;
    check("dout_in_reset", 32'(spi.ADC_DOUT), 32'd0);
    check("addr_in_reset", 32'(cur_addr), 32'd0);
    tick(1);
    spi.ADC_CS_N = 1'b1;
    spi.ADC_SCLK = 1'b0;
    tick(4);
    rst_n = 1'b1;
    m_lfsr = 16'hACE1;
    tick(5);

    full_frame(16'h1000, ch[0], 3'd2, 1'b0);
    check("addr_after_reset", 32'(cur_addr), 32'd2);

    ch[2] = 12'h321;
    full_frame(16'h3000, ch[2], 3'd6, 1'b1);
    check("addr_simul_end", 32'(cur_addr), 32'd6);

    ch[6] = 12'h00F;
    full_frame(16'h0000, ch[6], 3'd0, 1'b0);
    check("addr_last", 32'(cur_addr), 32'd0);

    tick(10);
    check("queue_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
